ex_result_stage: RTL and testbench

Execute-to-memory result stage of the RV32I core. It consumes the combinational ALU outputs (result, zero flag, less flag) together with the decoded control of the same instruction. From these it forms the final writeback value, resolves conditional branches and jumps, and emits a one-cycle PC redirect. It holds the result in a 2-entry skid buffer with valid/ready handshakes on both sides, so the ALU input registers are never stalled combinationally by the memory stage.

---
 rtl/ex_result_stage.sv | 113 +++++++++++
 tb/tb_ex_result_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_result_stage.sv
// ex_result_stage: selects the writeback value, resolves branches/jumps into a one-cycle
// PC redirect, and buffers results in a 2-entry skid buffer toward the memory stage.
module ex_result_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] aluResult,
    input  logic        zeroFlag,
    input  logic        lessFlag,
    input  logic [3:0]  aluCtrl,
    input  logic        isBranch,
    input  logic        isJump,
    input  logic [2:0]  brFunct3,
    input  logic [31:0] branchTarget,
    input  logic [31:0] pcPlus4,
    input  logic [4:0]  rdAddr,
    input  logic        regWrite,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] storeData,
    input  logic        flush,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] outResult,
    output logic [31:0] outStoreData,
    output logic [4:0]  outRd,
    output logic        outRegWrite,
    output logic        outMemRead,
    output logic        outMemWrite,
    output logic        redirect,
    output logic [31:0] redirectPc
);
    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } beat_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e      state_q, state_d;
    beat_t       main_q, main_d, skid_q, skid_d, in_beat;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        accept, consume, br_cond, taken, load_main, load_skid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= EMPTY;
            main_q        <= '0;
            skid_q        <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            main_q        <= main_d;
            skid_q        <= skid_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        state_d = flush                ? EMPTY :
                  (state_q == EMPTY)   ? (accept ? ONE : EMPTY) :
                  (state_q == ONE)     ? ((accept && !consume) ? TWO :
                                          (!accept && consume) ? EMPTY : ONE) :
                                         (consume ? ONE : TWO);
    end

    always_comb begin
        inReady      = (state_q != TWO);
        outValid     = (state_q != EMPTY);
        outResult    = main_q.result;
        outStoreData = main_q.store_data;
        outRd        = main_q.rd;
        outRegWrite  = main_q.reg_write;
        outMemRead   = main_q.mem_read;
        outMemWrite  = main_q.mem_write;
        redirect     = redirect_q;
        redirectPc   = redirect_pc_q;
    end

    always_comb begin
        accept             = inValid && inReady && !flush;
        consume            = outValid && outReady;
        in_beat.result     = isJump ? pcPlus4 :
                             (aluCtrl == 4'b0001 || aluCtrl == 4'b0010) ? {31'b0, lessFlag} :
                             aluResult;
        in_beat.store_data = storeData;
        in_beat.rd         = rdAddr;
        in_beat.reg_write  = regWrite && !isBranch;
        in_beat.mem_read   = memRead;
        in_beat.mem_write  = memWrite;
        // funct3[2] selects the less-based compares; funct3[0] inverts them
        br_cond            = (brFunct3 == 3'b000) ? zeroFlag :
                             (brFunct3 == 3'b001) ? !zeroFlag :
                             brFunct3[2]          ? (lessFlag ^ brFunct3[0]) : 1'b0;
        taken              = isJump || (isBranch && br_cond);
        // In TWO the main slot refills from skid; otherwise from the incoming beat
        load_main          = !flush && ((state_q == EMPTY) ? accept :
                                        (state_q == ONE)   ? (accept && consume) : consume);
        load_skid          = !flush && (state_q == ONE) && accept && !consume;
        main_d             = load_main ? ((state_q == TWO) ? skid_q : in_beat) : main_q;
        skid_d             = load_skid ? in_beat : skid_q;
        redirect_d         = accept && taken;
        redirect_pc_d      = redirect_d ? branchTarget : '0;
    end
endmodule

// File: tb/tb_ex_result_stage.sv
// tb_ex_result_stage: scenario tasks for ex_result_stage with a queue scoreboard of expected beats.
module tb_ex_result_stage;
    logic        clk = 1'b0;
    logic        rst, inValid, inReady, zeroFlag, lessFlag, isBranch, isJump;
    logic [31:0] aluResult, branchTarget, pcPlus4, storeData;
    logic [3:0]  aluCtrl;
    logic [2:0]  brFunct3;
    logic [4:0]  rdAddr, outRd;
    logic        regWrite, memRead, memWrite, flush, outValid, outReady;
    logic [31:0] outResult, outStoreData, redirectPc;
    logic        outRegWrite, outMemRead, outMemWrite, redirect;
    logic [71:0] out_beat, exp_b;
    logic [71:0] q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    ex_result_stage dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .aluResult(aluResult), .zeroFlag(zeroFlag), .lessFlag(lessFlag), .aluCtrl(aluCtrl),
        .isBranch(isBranch), .isJump(isJump), .brFunct3(brFunct3),
        .branchTarget(branchTarget), .pcPlus4(pcPlus4), .rdAddr(rdAddr),
        .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite), .storeData(storeData),
        .flush(flush), .outValid(outValid), .outReady(outReady),
        .outResult(outResult), .outStoreData(outStoreData), .outRd(outRd),
        .outRegWrite(outRegWrite), .outMemRead(outMemRead), .outMemWrite(outMemWrite),
        .redirect(redirect), .redirectPc(redirectPc)
    );

    always #5 clk = ~clk;
    assign out_beat = {outResult, outStoreData, outRd, outRegWrite, outMemRead, outMemWrite};

    function automatic logic [71:0] model(input logic [3:0] ctrl, input logic [31:0] res,
                                          input logic l, br, jmp, input logic [31:0] pc4,
                                          input logic [4:0] rd, input logic rw, mr, mw,
                                          input logic [31:0] sd);
        logic [31:0] r;
        if (jmp) r = pc4;
        else if (ctrl == 4'd1 || ctrl == 4'd2) r = {31'd0, l};
        else r = res;
        return {r, sd, rd, rw & ~br, mr, mw};
    endfunction

    task automatic drive(input logic v, input logic [3:0] ctrl, input logic [31:0] res,
                         input logic z, l, br, jmp, input logic [2:0] f3,
                         input logic [31:0] tgt, pc4, input logic [4:0] rd,
                         input logic rw, mr, mw, input logic [31:0] sd, input bit acc);
        inValid = v; aluCtrl = ctrl; aluResult = res; zeroFlag = z; lessFlag = l;
        isBranch = br; isJump = jmp; brFunct3 = f3; branchTarget = tgt; pcPlus4 = pc4;
        rdAddr = rd; regWrite = rw; memRead = mr; memWrite = mw; storeData = sd;
        if (acc) q.push_back(model(ctrl, res, l, br, jmp, pc4, rd, rw, mr, mw, sd));
    endtask

    task automatic idle();
        drive(0, 4'd0, 32'd0, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 32'd0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; outReady = 0; idle();
        step(); step();
        n_cmp++; if (outValid !== 1'b0) begin n_bad++; $display("FAIL reset_outValid got %b want 0", outValid); end
        n_cmp++; if (inReady !== 1'b1) begin n_bad++; $display("FAIL reset_inReady got %b want 1", inReady); end
        n_cmp++; if (redirect !== 1'b0) begin n_bad++; $display("FAIL reset_redirect got %b want 0", redirect); end
        n_cmp++; if (redirectPc !== 32'd0) begin n_bad++; $display("FAIL reset_redirectPc got %h want 0", redirectPc); end
        n_cmp++; if (out_beat !== 72'd0) begin n_bad++; $display("FAIL reset_outputs got %h want 0", out_beat); end
        rst = 0;
    endtask

    task automatic test_add();
        outReady = 1;
        drive(1, 4'd0, 32'd5, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd3, 1, 0, 0, 32'hA5A5_0000, 1);
        step(); idle();
        exp_b = q.pop_front();
        n_cmp++; if (outValid !== 1'b1 || out_beat !== exp_b) begin n_bad++; $display("FAIL add_beat got v=%b %h want %h", outValid, out_beat, exp_b); end
        n_cmp++; if (outResult !== 32'd5 || outRd !== 5'd3 || outRegWrite !== 1'b1) begin n_bad++; $display("FAIL add_fields got %h rd=%0d rw=%b want 5 rd=3 rw=1", outResult, outRd, outRegWrite); end
        n_cmp++; if (redirect !== 1'b0) begin n_bad++; $display("FAIL add_redirect got %b want 0", redirect); end
        step();
        n_cmp++; if (outValid !== 1'b0) begin n_bad++; $display("FAIL add_drain got %b want 0", outValid); end
    endtask

    task automatic test_sltu();
        outReady = 1;
        drive(1, 4'b0010, 32'hDEAD_BEEF, 0, 1, 0, 0, 3'd0, 32'd0, 32'd0, 5'd5, 1, 0, 0, 32'd0, 1);
        step();
        drive(1, 4'b0010, 32'hDEAD_BEEF, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd6, 1, 0, 1, 32'h1234_5678, 1);
        exp_b = q.pop_front();
        n_cmp++; if (outValid !== 1'b1 || out_beat !== exp_b || outResult !== 32'd1) begin n_bad++; $display("FAIL sltu_less1 got v=%b %h want %h", outValid, out_beat, exp_b); end
        step(); idle();
        exp_b = q.pop_front();
        n_cmp++; if (outValid !== 1'b1 || out_beat !== exp_b || outResult !== 32'd0) begin n_bad++; $display("FAIL sltu_less0 got v=%b %h want %h", outValid, out_beat, exp_b); end
        step();
    endtask

    task automatic test_branches();
        outReady = 1;
        drive(1, 4'd0, 32'd0, 1, 0, 1, 0, 3'b000, 32'h100, 32'h44, 5'd7, 1, 0, 0, 32'd0, 1);
        step(); idle();
        exp_b = q.pop_front();
        n_cmp++; if (redirect !== 1'b1 || redirectPc !== 32'h100) begin n_bad++; $display("FAIL beq_redirect got %b %h want 1 00000100", redirect, redirectPc); end
        n_cmp++; if (outValid !== 1'b1 || out_beat !== exp_b || outRegWrite !== 1'b0) begin n_bad++; $display("FAIL beq_beat got v=%b %h want %h", outValid, out_beat, exp_b); end
        step();
        n_cmp++; if (redirect !== 1'b0 || redirectPc !== 32'd0) begin n_bad++; $display("FAIL beq_pulse_end got %b %h want 0 0", redirect, redirectPc); end
        drive(1, 4'd0, 32'd9, 0, 1, 1, 0, 3'b111, 32'h200, 32'h48, 5'd8, 1, 0, 0, 32'd0, 1);
        step(); idle();
        exp_b = q.pop_front();
        n_cmp++; if (redirect !== 1'b0) begin n_bad++; $display("FAIL bgeu_redirect got %b want 0", redirect); end
        n_cmp++; if (outValid !== 1'b1 || out_beat !== exp_b) begin n_bad++; $display("FAIL bgeu_beat got v=%b %h want %h", outValid, out_beat, exp_b); end
        step();
        drive(1, 4'd0, 32'd0, 1, 1, 1, 0, 3'b010, 32'h300, 32'h4C, 5'd9, 1, 0, 0, 32'd0, 1);
        step(); idle();
        exp_b = q.pop_front();
        n_cmp++; if (redirect !== 1'b0) begin n_bad++; $display("FAIL f3_010_redirect got %b want 0", redirect); end
        n_cmp++; if (outValid !== 1'b1 || out_beat !== exp_b) begin n_bad++; $display("FAIL f3_010_beat got v=%b %h want %h", outValid, out_beat, exp_b); end
        step();
        drive(1, 4'd0, 32'd0, 0, 1, 1, 0, 3'b100, 32'h340, 32'h50, 5'd1, 0, 0, 0, 32'd0, 1);
        step(); idle();
        void'(q.pop_front());
        n_cmp++; if (redirect !== 1'b1 || redirectPc !== 32'h340) begin n_bad++; $display("FAIL blt_redirect got %b %h want 1 00000340", redirect, redirectPc); end
        step();
    endtask

    task automatic test_jal();
        outReady = 1;
        drive(1, 4'd0, 32'h1234, 0, 0, 0, 1, 3'd0, 32'h80, 32'h24, 5'd1, 1, 0, 0, 32'd0, 1);
        step(); idle();
        exp_b = q.pop_front();
        n_cmp++; if (outResult !== 32'h24 || outRegWrite !== 1'b1 || out_beat !== exp_b) begin n_bad++; $display("FAIL jal_beat got %h want %h", out_beat, exp_b); end
        n_cmp++; if (redirect !== 1'b1 || redirectPc !== 32'h80) begin n_bad++; $display("FAIL jal_redirect got %b %h want 1 00000080", redirect, redirectPc); end
        step();
    endtask

    task automatic test_back_pressure();
        outReady = 0;
        drive(1, 4'd0, 32'hAAAA_0001, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd10, 1, 1, 0, 32'd0, 1);
        step();
        n_cmp++; if (outValid !== 1'b1 || out_beat !== q[0] || inReady !== 1'b1) begin n_bad++; $display("FAIL bp_a got v=%b %h rdy=%b want %h rdy=1", outValid, out_beat, inReady, q[0]); end
        drive(1, 4'd0, 32'hBBBB_0002, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd11, 0, 0, 1, 32'h5555, 1);
        step();
        n_cmp++; if (out_beat !== q[0] || inReady !== 1'b0) begin n_bad++; $display("FAIL bp_full got %h rdy=%b want %h rdy=0", out_beat, inReady, q[0]); end
        drive(1, 4'd0, 32'hCCCC_0003, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd12, 1, 0, 0, 32'd0, 1);
        step();
        n_cmp++; if (outValid !== 1'b1 || out_beat !== q[0] || inReady !== 1'b0) begin n_bad++; $display("FAIL bp_hold got %h rdy=%b want %h rdy=0", out_beat, inReady, q[0]); end
        outReady = 1;
        void'(q.pop_front());
        step();
        n_cmp++; if (outValid !== 1'b1 || out_beat !== q[0] || inReady !== 1'b1) begin n_bad++; $display("FAIL bp_b got %h rdy=%b want %h rdy=1", out_beat, inReady, q[0]); end
        void'(q.pop_front());
        step(); idle();
        exp_b = q.pop_front();
        n_cmp++; if (outValid !== 1'b1 || out_beat !== exp_b) begin n_bad++; $display("FAIL bp_c got v=%b %h want %h", outValid, out_beat, exp_b); end
        step();
        n_cmp++; if (outValid !== 1'b0) begin n_bad++; $display("FAIL bp_drain got %b want 0", outValid); end
    endtask

    task automatic test_flush();
        outReady = 0;
        drive(1, 4'd0, 32'h11, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd2, 1, 0, 0, 32'd0, 0);
        step();
        drive(1, 4'd0, 32'h22, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd3, 1, 0, 0, 32'd0, 0);
        step();
        drive(1, 4'd0, 32'd0, 1, 0, 1, 0, 3'b000, 32'h500, 32'h60, 5'd4, 1, 0, 0, 32'd0, 0);
        flush = 1;
        step(); idle(); flush = 0;
        n_cmp++; if (outValid !== 1'b0 || redirect !== 1'b0 || inReady !== 1'b1) begin n_bad++; $display("FAIL flush got v=%b redir=%b rdy=%b want 0 0 1", outValid, redirect, inReady); end
        step();
        n_cmp++; if (outValid !== 1'b0 || redirect !== 1'b0) begin n_bad++; $display("FAIL flush_after got v=%b redir=%b want 0 0", outValid, redirect); end
    endtask

    task automatic test_reset_mid();
        outReady = 0;
        drive(1, 4'd0, 32'h77, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd5, 1, 1, 1, 32'h99, 0);
        step();
        drive(1, 4'd0, 32'd0, 0, 0, 0, 1, 3'd0, 32'h300, 32'h64, 5'd6, 1, 0, 0, 32'd0, 0);
        rst = 1;
        step(); idle(); rst = 0;
        n_cmp++; if (outValid !== 1'b0 || inReady !== 1'b1) begin n_bad++; $display("FAIL rstmid_hs got v=%b rdy=%b want 0 1", outValid, inReady); end
        n_cmp++; if (redirect !== 1'b0 || redirectPc !== 32'd0) begin n_bad++; $display("FAIL rstmid_redirect got %b %h want 0 0", redirect, redirectPc); end
        n_cmp++; if (out_beat !== 72'd0) begin n_bad++; $display("FAIL rstmid_outputs got %h want 0", out_beat); end
        outReady = 1;
        drive(1, 4'b0001, 32'h0, 0, 1, 0, 0, 3'd0, 32'd0, 32'd0, 5'd31, 1, 0, 0, 32'hFFFF_FFFF, 1);
        step(); idle();
        exp_b = q.pop_front();
        n_cmp++; if (outValid !== 1'b1 || out_beat !== exp_b) begin n_bad++; $display("FAIL post_reset_slt got v=%b %h want %h", outValid, out_beat, exp_b); end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sltu();
        test_branches();
        test_jal();
        test_back_pressure();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
